// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared types and constants for the buart FIFO controller.
package uart_fifo_pkg;
  localparam int BYTE_W = 8;
  localparam int ERR_TXOVF = 0;
  localparam int ERR_RXOVR = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} tx_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// uart_fifo_ctrl_if: handshake bundle between the FIFO controller (master) and buart (slave).
interface uart_fifo_ctrl_if import uart_fifo_pkg::*; ();
  logic u_wr;
  logic [BYTE_W-1:0] u_tx_data;
  logic u_busy;
  logic u_rd;
  logic u_valid;
  logic [BYTE_W-1:0] u_rx_data;
  modport master (output u_wr, u_tx_data, u_rd, input u_busy, u_valid, u_rx_data);
  modport slave (input u_wr, u_tx_data, u_rd, output u_busy, u_valid, u_rx_data);
endinterface

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; push is judged on pre-pop fullness.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic resetq,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [DEPTH_LOG2:0] level
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign level = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // Empty reads as zero so the CPU never sees stale storage.
  assign dout = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(do_push);
      rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: TX/RX FIFOs sequencing buart for the j1 IO bus.
// Optional byte counters enabled by defining UART_FIFO_CNT_EN.
module uart_fifo_ctrl import uart_fifo_pkg::*; #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic clk,
  input  logic resetq,
  input  logic tx_wr,
  input  logic [BYTE_W-1:0] tx_data,
  output logic tx_full,
  output logic tx_empty,
  output logic [DEPTH_LOG2:0] tx_level,
  input  logic rx_rd,
  output logic [BYTE_W-1:0] rx_data,
  output logic rx_avail,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic [1:0] err,
  input  logic err_clr,
`ifdef UART_FIFO_CNT_EN
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
`endif
  uart_fifo_ctrl_if.master bus
);
  tx_state_t state;
  logic tx_fifo_empty, tx_pop;
  logic [BYTE_W-1:0] tx_head;
  logic rx_fifo_full, rx_fifo_empty, rx_hold, rx_capture;
  logic [BYTE_W-1:0] rx_byte;
  assign tx_pop = state == IDLE && !tx_fifo_empty && !bus.u_busy;
  assign tx_empty = tx_fifo_empty && state == IDLE;
  assign rx_avail = !rx_fifo_empty;
  // u_rd itself also blocks capture so valid held through the ack is taken once.
  assign rx_capture = bus.u_valid && !bus.u_rd && !rx_hold;
  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(BYTE_W)) tx_fifo (
    .clk(clk), .resetq(resetq), .push(tx_wr), .pop(tx_pop), .din(tx_data),
    .dout(tx_head), .full(tx_full), .empty(tx_fifo_empty), .level(tx_level)
  );
  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(BYTE_W)) rx_fifo (
    .clk(clk), .resetq(resetq), .push(bus.u_rd), .pop(rx_rd), .din(rx_byte),
    .dout(rx_data), .full(rx_fifo_full), .empty(rx_fifo_empty), .level(rx_level)
  );
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      state <= IDLE;
      bus.u_wr <= 1'b0;
      bus.u_tx_data <= '0;
    end else begin
      bus.u_wr <= tx_pop;
      if (tx_pop) bus.u_tx_data <= tx_head;
      state <= state == IDLE   ? (tx_pop ? LAUNCH : IDLE) :
               state == LAUNCH ? HOLD :
               state == HOLD   ? DRAIN :
               (bus.u_busy ? DRAIN : IDLE);
    end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      bus.u_rd <= 1'b0;
      rx_hold <= 1'b0;
      rx_byte <= '0;
    end else begin
      bus.u_rd <= rx_capture;
      rx_hold <= bus.u_rd;
      if (rx_capture) rx_byte <= bus.u_rx_data;
    end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) err <= 2'b00;
    else begin
      err[ERR_TXOVF] <= (err[ERR_TXOVF] && !err_clr) || (tx_wr && tx_full);
      err[ERR_RXOVR] <= (err[ERR_RXOVR] && !err_clr) || (bus.u_rd && rx_fifo_full);
    end
`ifdef UART_FIFO_CNT_EN
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      tx_count <= err_clr ? '0 : tx_pop ? sat_inc(tx_count) : tx_count;
      rx_count <= err_clr ? '0 : (bus.u_rd && !rx_fifo_full) ? sat_inc(rx_count) : rx_count;
    end
`endif
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: randomized and directed checks against a queue-based behavioural model.
module tb_uart_fifo_ctrl;
  logic clk = 0, resetq = 0;
  logic tx_wr = 0, rx_rd = 0, err_clr = 0;
  logic [7:0] tx_data = 0;
  logic tx_full, tx_empty, rx_avail;
  logic [4:0] tx_level, rx_level;
  logic [7:0] rx_data;
  logic [1:0] err;
`ifdef UART_FIFO_CNT_EN
  logic [15:0] tx_count, rx_count;
`endif
  uart_fifo_ctrl_if bus();
  uart_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .resetq(resetq), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .tx_empty(tx_empty), .tx_level(tx_level), .rx_rd(rx_rd), .rx_data(rx_data),
    .rx_avail(rx_avail), .rx_level(rx_level), .err(err), .err_clr(err_clr),
`ifdef UART_FIFO_CNT_EN
    .tx_count(tx_count), .rx_count(rx_count),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Behavioural model: queues for the FIFOs, a cooldown for the transmitter,
  // and an ack/guard pair for the receiver.
  byte unsigned txq[$], rxq[$];
  bit m_free, m_wr, m_rd, m_hold, pop, ovf0, ovf1, new_rd;
  int m_since, txn, rxn;
  logic [7:0] m_txd, m_rxb;
  logic [1:0] m_err;
  always @(posedge clk or negedge resetq)
    if (!resetq) begin
      txq.delete(); rxq.delete();
      m_free = 1; m_since = 0; m_wr = 0; m_txd = 0;
      m_rd = 0; m_hold = 0; m_rxb = 0; m_err = 0;
    end else begin
      txn = txq.size(); rxn = rxq.size();
      pop = m_free && txn > 0 && !bus.u_busy;
      if (pop) begin m_free = 0; m_since = 0; m_txd = txq.pop_front(); end
      else if (!m_free) begin
        if (m_since < 2) m_since++;
        else if (!bus.u_busy) m_free = 1;
      end
      m_wr = pop;
      ovf0 = tx_wr && txn == 16;
      if (tx_wr && txn < 16) txq.push_back(tx_data);
      ovf1 = m_rd && rxn == 16;
      if (rx_rd && rxn > 0) void'(rxq.pop_front());
      if (m_rd && rxn < 16) rxq.push_back(m_rxb);
      new_rd = bus.u_valid && !m_rd && !m_hold;
      m_hold = m_rd;
      if (new_rd) m_rxb = bus.u_rx_data;
      m_rd = new_rd;
      m_err[0] = (m_err[0] && !err_clr) || ovf0;
      m_err[1] = (m_err[1] && !err_clr) || ovf1;
    end

  int cyc = 0, last_wr = -1000, min_gap = 1000, wr_cnt = 0, rd_cnt = 0;
  byte unsigned wr_log[$];
  always @(negedge clk) begin
    cyc++;
    if (resetq) begin
      chk("u_wr", bus.u_wr, m_wr);
      chk("u_tx_data", bus.u_tx_data, m_txd);
      chk("tx_level", tx_level, txq.size());
      chk("tx_full", tx_full, txq.size() == 16);
      chk("tx_empty", tx_empty, txq.size() == 0 && m_free);
      chk("u_rd", bus.u_rd, m_rd);
      chk("rx_level", rx_level, rxq.size());
      chk("rx_avail", rx_avail, rxq.size() > 0);
      chk("rx_data", rx_data, rxq.size() > 0 ? rxq[0] : 8'h00);
      chk("err", err, m_err);
    end
    if (bus.u_wr) begin
      wr_cnt++; wr_log.push_back(bus.u_tx_data);
      if (cyc - last_wr < min_gap) min_gap = cyc - last_wr;
      last_wr = cyc;
    end
    if (bus.u_rd) rd_cnt++;
  end

  // buart stand-in: busy after each write, RX bytes offered from a queue.
  int bcnt = 0, busy_len = 10;
  bit busy_force = 0, auto_rx = 0;
  byte unsigned src[$];
  task automatic tick();
    @(negedge clk);
    if (bus.u_wr) bcnt = busy_len;
    bus.u_busy = busy_force || bcnt > 0;
    if (bcnt > 0) bcnt--;
    if (auto_rx) begin
      if (bus.u_valid && bus.u_rd) bus.u_valid = 0;
      else if (!bus.u_valid && src.size() > 0 && $urandom_range(1, 0) == 1) begin
        bus.u_valid = 1; bus.u_rx_data = src.pop_front();
      end
    end
  endtask
  task automatic do_reset();
    resetq = 0; tx_wr = 0; rx_rd = 0; err_clr = 0; bus.u_valid = 0; bus.u_busy = 0;
    src.delete(); bcnt = 0; busy_force = 0; auto_rx = 0;
    tick(); tick();
    resetq = 1;
  endtask
  task automatic wait_tx_idle(string n, int lim);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin tick(); ok = tx_empty && !bus.u_busy; end
    chk(n, ok, 1);
  endtask

  initial begin
    bus.u_busy = 0; bus.u_valid = 0; bus.u_rx_data = 0;
    do_reset();
    chk("rst_tx_level", tx_level, 0); chk("rst_tx_empty", tx_empty, 1);
    chk("rst_u_wr", bus.u_wr, 0); chk("rst_err", err, 0); chk("rst_rx_data", rx_data, 0);

    // Three bytes, busy for 10 cycles after each write
    busy_len = 10; wr_log.delete();
    tick(); tx_wr = 1; tx_data = 8'h41;
    tick(); tx_data = 8'h42; chk("lat_c1_u_wr", bus.u_wr, 0);
    tick(); tx_data = 8'h43; chk("lat_c2_u_wr", bus.u_wr, 1); chk("lat_c2_data", bus.u_tx_data, 8'h41);
    tick(); tx_wr = 0;
    wait_tx_idle("t1_drain", 200);
    chk("t1_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("t1_b0", wr_log[0], 8'h41); chk("t1_b1", wr_log[1], 8'h42); chk("t1_b2", wr_log[2], 8'h43);
    end
    chk("t1_tx_empty", tx_empty, 1);

    // 17 pushes with busy held high
    do_reset(); busy_force = 1; wr_log.delete();
    tick();
    for (int i = 0; i < 17; i++) begin tx_wr = 1; tx_data = 8'(8'h60 + i); tick(); end
    tx_wr = 0; tick(); tick();
    chk("t2_level", tx_level, 16); chk("t2_full", tx_full, 1); chk("t2_err", err, 2'b01);
    chk("t2_no_wr", wr_log.size(), 0);
    busy_force = 0; busy_len = 2;
    wait_tx_idle("t2_drain", 400);
    chk("t2_sent", wr_log.size(), 16);
    if (wr_log.size() == 16) chk("t2_last", wr_log[15], 8'h6F);

    // u_valid held three cycles gives one ack
    do_reset(); rd_cnt = 0;
    tick(); bus.u_valid = 1; bus.u_rx_data = 8'h5A;
    tick(); chk("t3_c1_u_rd", bus.u_rd, 1); chk("t3_c1_avail", rx_avail, 0);
    tick(); chk("t3_c2_avail", rx_avail, 1); chk("t3_c2_data", rx_data, 8'h5A);
    tick(); bus.u_valid = 0;
    tick(); tick(); tick();
    chk("t3_rd_cnt", rd_cnt, 1); chk("t3_level", rx_level, 1);

    // 17 RX bytes with no reads
    do_reset(); rd_cnt = 0; auto_rx = 1;
    for (int i = 0; i < 17; i++) src.push_back(8'(8'h10 + i));
    for (int i = 0; i < 300 && (src.size() > 0 || bus.u_valid); i++) tick();
    tick(); tick(); tick(); tick();
    chk("t4_rd_cnt", rd_cnt, 17); chk("t4_level", rx_level, 16);
    chk("t4_err", err, 2'b10); chk("t4_head", rx_data, 8'h10);

    // Full RX: pop and capture in the same cycle
    auto_rx = 0; err_clr = 1; tick(); err_clr = 0; tick();
    chk("t5_err_clr0", err, 0);
    bus.u_valid = 1; bus.u_rx_data = 8'h99;
    for (int i = 0; i < 10 && !bus.u_rd; i++) tick();
    chk("t5_saw_u_rd", bus.u_rd, 1);
    rx_rd = 1; bus.u_valid = 0;
    tick(); rx_rd = 0; tick();
    chk("t5_level", rx_level, 15); chk("t5_err", err, 2'b10); chk("t5_head", rx_data, 8'h11);
    err_clr = 1; tick(); err_clr = 0; tick();
    chk("t5_err_clr", err, 0);

    // Reset while draining with five queued
    do_reset(); busy_len = 30; wr_cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); tx_wr = 1; tx_data = 8'(8'h70 + i); end
    tick(); tx_wr = 0; tick(); tick(); tick();
    chk("t6_level_pre", tx_level, 5);
    resetq = 0; #1;
    chk("t6_level", tx_level, 0); chk("t6_u_wr", bus.u_wr, 0); chk("t6_u_tx_data", bus.u_tx_data, 0);
    chk("t6_tx_empty", tx_empty, 1); chk("t6_err", err, 0); chk("t6_u_rd", bus.u_rd, 0);
    tick(); bcnt = 0; resetq = 1; wr_cnt = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_no_wr", wr_cnt, 0);

    // Back-to-back launches with an idle transmitter
    do_reset(); busy_len = 0; min_gap = 1000;
    for (int i = 0; i < 60; i++) begin tick(); tx_wr = 1; tx_data = 8'($urandom); end
    tick(); tx_wr = 0;
    wait_tx_idle("gap_drain", 200);
    chk("min_wr_gap", min_gap, 4);

    // Random traffic
    do_reset(); auto_rx = 1;
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (src.size() == 0) for (int k = 0; k < 8; k++) src.push_back(8'($urandom));
      busy_len = $urandom_range(6, 0);
      tx_wr = $urandom_range(2, 0) == 0; tx_data = 8'($urandom);
      rx_rd = $urandom_range(3, 0) == 0;
      err_clr = $urandom_range(63, 0) == 0;
    end
    tx_wr = 0; rx_rd = 0; err_clr = 0; auto_rx = 0; bus.u_valid = 0;
    wait_tx_idle("rand_drain", 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
